dmem_io: RTL and testbench

Parametrised data memory with a memory-mapped packet I/O window for the processing unit. The lower half of the address space is word RAM; the upper half holds an RX FIFO, a TX FIFO, a status register and a control register. The FIFOs connect to the NIC through valid/ready handshakes. Packets arriving while the core is busy are buffered rather than lost, and bus errors set sticky flags.

---
 rtl/dmem_io.sv | 180 ++++++++++++++++++
 tb/tb_dmem_io.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io.sv
// dmem_io: word RAM in the lower half of the address space, and a packet I/O
// window in the upper half. The window holds RX/TX FIFOs, STATUS and CTRL.
// Optional feature macro: DMEM_IO_IRQ_EN enables the CTRL register and the
// registered irq output. Without the macro, irq is tied low and CTRL reads 0.
//
// Handshake (both NIC ports): a transfer happens on a posedge where valid and
// ready are both high. valid never depends on ready. A producer holding valid
// with ready low keeps its data stable until the transfer occurs.
module dmem_io #(
  parameter int WIDTH = 16,
  parameter int AW    = 8,
  parameter int PW    = 10,
  parameter int FD    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ad,
  input  logic [WIDTH-1:0] wd,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] rd,
  input  logic [PW-1:0]    pkt_in,
  input  logic             pkt_in_valid,
  output logic             pkt_in_ready,
  output logic [PW-1:0]    pkt_out,
  output logic             pkt_out_valid,
  input  logic             pkt_out_ready,
  output logic             irq
);

  localparam int PTRW = $clog2(FD);
  localparam int CW   = PTRW + 1;
  localparam logic [AW-2:0] OFF_RX = (AW-1)'(0);
  localparam logic [AW-2:0] OFF_TX = (AW-1)'(1);
  localparam logic [AW-2:0] OFF_ST = (AW-1)'(2);
  localparam logic [AW-2:0] OFF_CT = (AW-1)'(3);

  // Storage arrays carry no reset; FIFO contents are qualified by the counts.
  logic [WIDTH-1:0] ram    [2**(AW-1)];
  logic [PW-1:0]    rx_mem [FD];
  logic [PW-1:0]    tx_mem [FD];

  logic [PTRW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [PTRW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic            rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
  // Holds pkt_in_ready low until the first clock edge after reset release.
  logic            live_q;

  logic          io_sel;
  logic [AW-2:0] off;
  logic          rx_full, rx_nempty, tx_full, tx_empty;
  logic          rx_push, rx_rd, rx_pop, tx_wr, tx_push, tx_pop, st_wr;
  logic          unused_wd;

  assign io_sel    = ad[AW-1];
  assign off       = ad[AW-2:0];
  assign rx_full   = (rx_cnt_q == CW'(FD));
  assign rx_nempty = (rx_cnt_q != '0);
  assign tx_full   = (tx_cnt_q == CW'(FD));
  assign tx_empty  = (tx_cnt_q == '0);

  assign pkt_in_ready  = live_q && !rx_full;
  assign pkt_out_valid = !tx_empty;
  assign pkt_out       = tx_empty ? '0 : tx_mem[tx_rp_q];

  assign rx_push = pkt_in_valid && pkt_in_ready;
  assign rx_rd   = io_sel && (off == OFF_RX) && re;
  assign rx_pop  = rx_rd && rx_nempty;
  // Full is sampled before the edge, so a core push into a full TX FIFO is
  // dropped even when the NIC pops on the same edge.
  assign tx_wr   = io_sel && (off == OFF_TX) && we;
  assign tx_push = tx_wr && !tx_full;
  assign tx_pop  = pkt_out_valid && pkt_out_ready;
  assign st_wr   = io_sel && (off == OFF_ST) && we;

  // Only the low bits of wd reach state; fold the rest into a sink.
  assign unused_wd = ^wd;

  // Next-state for FIFO pointers, counts and sticky error flags (set wins).
  always_comb begin
    rx_wp_d  = rx_wp_q + PTRW'(rx_push);
    rx_rp_d  = rx_rp_q + PTRW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_wp_d  = tx_wp_q + PTRW'(tx_push);
    tx_rp_d  = tx_rp_q + PTRW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_unf_d = rx_unf_q;
    tx_ovf_d = tx_ovf_q;
    if (st_wr && wd[4]) rx_unf_d = 1'b0;
    if (st_wr && wd[5]) tx_ovf_d = 1'b0;
    if (rx_rd && !rx_nempty) rx_unf_d = 1'b1;
    if (tx_wr && tx_full) tx_ovf_d = 1'b1;
  end

  // Control state registers; reset empties both FIFOs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_unf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_unf_q <= rx_unf_d;
      tx_ovf_q <= tx_ovf_d;
      live_q   <= 1'b1;
    end
  end

  // Data storage writes: RAM words and FIFO slots.
  always_ff @(posedge clk) begin
    if (we && !io_sel) ram[off] <= wd;
    if (rx_push) rx_mem[rx_wp_q] <= pkt_in;
    if (tx_push) tx_mem[tx_wp_q] <= wd[PW-1:0];
  end

`ifdef DMEM_IO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  // CTRL write and interrupt condition, registered one cycle behind state.
  always_comb begin
    ctrl_d = ctrl_q;
    if (io_sel && (off == OFF_CT) && we) ctrl_d = wd[1:0];
    irq_d = (ctrl_q[0] && rx_nempty) || (ctrl_q[1] && (rx_unf_q || tx_ovf_q));
  end

  // IRQ and CTRL registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux over RAM and the I/O window.
  always_comb begin
    rd = '0;
    if (!io_sel) begin
      rd = ram[off];
    end else begin
      case (off)
        OFF_RX: if (rx_nempty) rd = WIDTH'(rx_mem[rx_rp_q]);
        OFF_ST: begin
          rd[0]    = rx_nempty;
          rd[1]    = rx_full;
          rd[2]    = tx_empty;
          rd[3]    = tx_full;
          rd[4]    = rx_unf_q;
          rd[5]    = tx_ovf_q;
          rd[15:8] = 8'(rx_cnt_q);
        end
`ifdef DMEM_IO_IRQ_EN
        OFF_CT: rd[1:0] = ctrl_q;
`endif
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
// Bench for dmem_io: queue-based reference model of RAM, FIFOs, flags and irq,
// directed scenarios from the test plan plus randomized mixed traffic.
module tb_dmem_io;
  localparam int WIDTH = 16;
  localparam int AW    = 8;
  localparam int PW    = 10;
  localparam int FD    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    ad;
  logic [WIDTH-1:0] wd;
  logic             we, re;
  logic [WIDTH-1:0] rd;
  logic [PW-1:0]    pkt_in, pkt_out;
  logic             pkt_in_valid, pkt_in_ready, pkt_out_valid, pkt_out_ready, irq;

  dmem_io #(.WIDTH(WIDTH), .AW(AW), .PW(PW), .FD(FD)) dut (
    .clk(clk), .rst_n(rst_n), .ad(ad), .wd(wd), .we(we), .re(re), .rd(rd),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] ram_m [128];
  logic [PW-1:0]    rx_q[$];
  logic [PW-1:0]    tx_q[$];
  bit               unf_m, ovf_m, started_m, irq_m;
  bit [1:0]         ctrl_m;

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    unf_m = 0; ovf_m = 0; started_m = 0; irq_m = 0; ctrl_m = 0;
  endtask

  function automatic logic [WIDTH-1:0] status_m();
    logic [WIDTH-1:0] s;
    s = '0;
    s[0] = (rx_q.size() > 0);
    s[1] = (rx_q.size() == FD);
    s[2] = (tx_q.size() == 0);
    s[3] = (tx_q.size() == FD);
    s[4] = unf_m;
    s[5] = ovf_m;
    s[15:8] = 8'(rx_q.size());
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
    if (!a[7]) return ram_m[a[6:0]];
    case (a)
      8'h80:   return (rx_q.size() > 0) ? WIDTH'(rx_q[0]) : '0;
      8'h82:   return status_m();
      8'h83:   return WIDTH'(ctrl_m);
      default: return '0;
    endcase
  endfunction

  function automatic bit exp_ready();
    return started_m && (rx_q.size() < FD);
  endfunction

  // One clock: update the model from the pre-edge inputs/state, then step.
  task automatic cyc();
    int rs = rx_q.size();
    int ts = tx_q.size();
    bit rx_rd   = re && (ad == 8'h80);
    bit tx_req  = we && (ad == 8'h81);
    bit rx_push = pkt_in_valid && started_m && (rs < FD);
    bit tx_pop  = (ts > 0) && pkt_out_ready;
    bit irq_n   = 0;
`ifdef DMEM_IO_IRQ_EN
    irq_n = (ctrl_m[0] && rs > 0) || (ctrl_m[1] && (unf_m || ovf_m));
    if (we && ad == 8'h83) ctrl_m = wd[1:0];
`endif
    if (we && !ad[7]) ram_m[ad[6:0]] = wd;
    if (we && ad == 8'h82) begin
      if (wd[4]) unf_m = 0;
      if (wd[5]) ovf_m = 0;
    end
    if (rx_rd && rs == 0) unf_m = 1;
    if (tx_req && ts == FD) ovf_m = 1;
    if (rx_rd && rs > 0) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(pkt_in);
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_req && ts < FD) tx_q.push_back(wd[PW-1:0]);
    started_m = 1;
    irq_m = irq_n;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                     input logic w, input logic r);
    ad = a; wd = d; we = w; re = r;
  endtask

  task automatic idle();
    bus(8'h82, '0, 1'b0, 1'b0);
    pkt_in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    pkt_in = '0; pkt_out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (pkt_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", pkt_in_ready); end
    total++; if (pkt_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", pkt_out_valid); end
    total++; if (pkt_out !== '0) begin bad++; $display("FAIL reset_pkt_out got=%h want=0", pkt_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL reset_status got=%h want=0004", rd); end
    #2 rst_n = 1'b1;
    #1;
    total++; if (pkt_in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", pkt_in_ready); end
    cyc();
    total++; if (pkt_in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b want=1", pkt_in_ready); end
  endtask

  task automatic test_ram();
    for (int i = 0; i < 128; i++) begin
      bus(AW'(i), WIDTH'($urandom), 1'b1, 1'b0);
      cyc();
    end
    bus(8'h05, 16'hBEEF, 1'b1, 1'b0);
    cyc();
    bus(8'h05, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ram_beef got=%h want=BEEF", rd); end
    bus(8'h80, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rx_empty_read got=%h want=0", rd); end
    bus(8'h05, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ram_untouched got=%h want=BEEF", rd); end
    for (int i = 0; i < 12; i++) begin
      bus(AW'($urandom_range(0, 127)), '0, 1'b0, 1'b0);
      #1;
      total++; if (rd !== exp_rd(ad)) begin bad++; $display("FAIL ram_rand ad=%h got=%h want=%h", ad, rd, exp_rd(ad)); end
    end
  endtask

  task automatic test_rx_fill();
    // Park one TX word so tx_empty is 0 and STATUS reads exactly 0x0403.
    pkt_out_ready = 1'b0;
    bus(8'h81, 16'h02A5, 1'b1, 1'b0);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      pkt_in = PW'(10'h101 + i);
      pkt_in_valid = 1'b1;
      cyc();
    end
    pkt_in_valid = 1'b0;
    total++; if (pkt_in_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready got=%b want=0", pkt_in_ready); end
    #1;
    total++; if (rd !== 16'h0403) begin bad++; $display("FAIL rx_full_status got=%h want=0403", rd); end
    for (int i = 0; i < 4; i++) begin
      bus(8'h80, '0, 1'b0, 1'b1);
      #1;
      total++; if (rd !== WIDTH'(16'h101 + i)) begin bad++; $display("FAIL rx_pop_%0d got=%h want=%h", i, rd, 16'h101 + i); end
      cyc();
    end
    idle();
    #1;
    total++; if (rd[0] !== 1'b0) begin bad++; $display("FAIL rx_drained_nempty got=%b want=0", rd[0]); end
    pkt_out_ready = 1'b1;
    cyc();
    pkt_out_ready = 1'b0;
    total++; if (pkt_out_valid !== 1'b0) begin bad++; $display("FAIL tx_park_drain got=%b want=0", pkt_out_valid); end
  endtask

  task automatic test_tx_backpressure();
    pkt_out_ready = 1'b0;
    bus(8'h81, 16'h03AA, 1'b1, 1'b0);
    cyc();
    bus(8'h81, 16'h0155, 1'b1, 1'b0);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (pkt_out_valid !== 1'b1 || pkt_out !== 10'h3AA) begin
        bad++; $display("FAIL tx_hold_%0d got=%b/%h want=1/3AA", i, pkt_out_valid, pkt_out); end
      cyc();
    end
    pkt_out_ready = 1'b1;
    #1;
    total++; if (pkt_out !== 10'h3AA) begin bad++; $display("FAIL tx_first got=%h want=3AA", pkt_out); end
    cyc();
    total++; if (pkt_out !== 10'h155) begin bad++; $display("FAIL tx_second got=%h want=155", pkt_out); end
    cyc();
    total++; if (pkt_out_valid !== 1'b0) begin bad++; $display("FAIL tx_done_valid got=%b want=0", pkt_out_valid); end
    pkt_out_ready = 1'b0;
  endtask

  task automatic test_errors();
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(8'h81, WIDTH'($urandom_range(0, 1023)), 1'b1, 1'b0);
      cyc();
    end
    bus(8'h81, 16'h03FF, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    total++; if (rd[5] !== 1'b1 || rd[3] !== 1'b1) begin bad++; $display("FAIL tx_overflow got=%h want bit5,bit3 set", rd); end
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (pkt_out !== tx_q[0]) begin bad++; $display("FAIL tx_drop_%0d got=%h want=%h", i, pkt_out, tx_q[0]); end
      cyc();
    end
    pkt_out_ready = 1'b0;
    total++; if (pkt_out_valid !== 1'b0) begin bad++; $display("FAIL tx_overflow_dropped got=%b want=0", pkt_out_valid); end
    bus(8'h80, '0, 1'b0, 1'b1);
    cyc();
    idle();
    #1;
    total++; if (rd[5:4] !== 2'b11) begin bad++; $display("FAIL both_flags got=%b want=11", rd[5:4]); end
    bus(8'h82, 16'h0010, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    total++; if (rd[5:4] !== 2'b10) begin bad++; $display("FAIL w1c_bit4 got=%b want=10", rd[5:4]); end
    bus(8'h80, '0, 1'b0, 1'b1);
    cyc();
    bus(8'h82, 16'h0030, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL w1c_both got=%h want=0004", rd); end
  endtask

  task automatic test_wrap();
    idle();
    for (int i = 0; i < 2; i++) begin
      pkt_in = PW'($urandom);
      pkt_in_valid = 1'b1;
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      pkt_in = PW'($urandom);
      pkt_in_valid = 1'b1;
      bus(8'h80, '0, 1'b0, 1'b1);
      #1;
      total++; if (rd !== WIDTH'(rx_q[0])) begin bad++; $display("FAIL wrap_head_%0d got=%h want=%h", i, rd, rx_q[0]); end
      total++; if (pkt_in_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_%0d got=%b want=1", i, pkt_in_ready); end
      cyc();
    end
    idle();
    #1;
    total++; if (rd[15:8] !== 8'd2) begin bad++; $display("FAIL wrap_count got=%0d want=2", rd[15:8]); end
    for (int i = 0; i < 2; i++) begin
      bus(8'h80, '0, 1'b0, 1'b1);
      #1;
      total++; if (rd !== exp_rd(8'h80)) begin bad++; $display("FAIL wrap_tail_%0d got=%h want=%h", i, rd, exp_rd(8'h80)); end
      cyc();
    end
    idle();
  endtask

  task automatic test_irq();
`ifdef DMEM_IO_IRQ_EN
    bus(8'h83, 16'h0001, 1'b1, 1'b0);
    cyc();
    bus(8'h83, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL ctrl_read got=%h want=0001", rd); end
    pkt_in = 10'h2C3; pkt_in_valid = 1'b1;
    cyc();
    pkt_in_valid = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b want=0", irq); end
    cyc();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", irq); end
    bus(8'h80, '0, 1'b0, 1'b1);
    cyc();
    idle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want=1", irq); end
    cyc();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
    bus(8'h83, '0, 1'b1, 1'b0);
    cyc();
    idle();
`else
    bus(8'h83, 16'h0003, 1'b1, 1'b0);
    cyc();
    bus(8'h83, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL ctrl_absent got=%h want=0", rd); end
    pkt_in = 10'h2C3; pkt_in_valid = 1'b1;
    cyc();
    pkt_in_valid = 1'b0;
    cyc();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied got=%b want=0", irq); end
    bus(8'h80, '0, 1'b0, 1'b1);
    cyc();
    idle();
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    bus(8'h80, WIDTH'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        2, 3:    bus(8'h81, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        4:       bus(8'h82, WIDTH'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        5:       bus(8'h83, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        6:       bus(AW'($urandom_range(8'h84, 8'hFF)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        default: bus(AW'($urandom_range(0, 127)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      endcase
      pkt_in        = PW'($urandom);
      pkt_in_valid  = 1'($urandom_range(0, 1));
      pkt_out_ready = 1'($urandom_range(0, 2) == 0);
      #1;
      total++; if (rd !== exp_rd(ad)) begin bad++; $display("FAIL rand_rd n=%0d ad=%h got=%h want=%h", n, ad, rd, exp_rd(ad)); end
      total++; if (pkt_in_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, pkt_in_ready, exp_ready()); end
      total++; if (pkt_out_valid !== (tx_q.size() > 0)) begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, pkt_out_valid, tx_q.size() > 0); end
      if (tx_q.size() > 0) begin
        total++; if (pkt_out !== tx_q[0]) begin bad++; $display("FAIL rand_pkt_out n=%0d got=%h want=%h", n, pkt_out, tx_q[0]); end
      end
      total++; if (irq !== irq_m) begin bad++; $display("FAIL rand_irq n=%0d got=%b want=%b", n, irq, irq_m); end
      cyc();
    end
    idle();
    pkt_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle();
    bus(8'h83, 16'h0003, 1'b1, 1'b0);
    pkt_in = 10'h077; pkt_in_valid = 1'b1;
    cyc();
    bus(8'h81, 16'h0123, 1'b1, 1'b0);
    cyc();
    bus(8'h82, '0, 1'b0, 1'b0);
    cyc();
    pkt_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (pkt_in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", pkt_in_ready); end
    total++; if (pkt_out_valid !== 1'b0 || pkt_out !== '0) begin bad++; $display("FAIL mid_tx got=%b/%h want=0/0", pkt_out_valid, pkt_out); end
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL mid_status got=%h want=0004", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b want=0", irq); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    started_m = 1;
    bus(8'h83, '0, 1'b0, 1'b0);
    #1;
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL mid_ctrl got=%h want=0", rd); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rx_fill();
    test_tx_backpressure();
    test_errors();
    test_wrap();
    test_irq();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
